truth_table_checker: RTL and testbench

Self-checking response monitor for the 3-input `truth_table` block: the sequential counterpart to the stimulus bench. On `start` it steps `{A,B,C}` through all eight combinations (000 → 111) and lets each settle. It samples the DUT output `Y`, compares it against an 8-bit expected truth table, and reports a per-vector fail map, an error count and a pass flag. It sits directly on the DUT's `A`, `B`, `C`, `Y` pins, so a `truth_table` instance can be checked in hardware (FPGA) or in simulation without a hand-written stimulus list.

---
 rtl/truth_table_checker.sv | 146 ++++++++++++++
 tb/tb_truth_table_checker.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
//
// Sequential response monitor for a 3-input combinational block. After an
// accepted start it drives the eight input vectors {A,B,C} = 000..111 in
// order. Each vector is held for SETTLE cycles and then for one sample cycle.
// At the edge that ends the sample cycle, Y is compared with the expected
// truth-table bit. A per-vector fail map, a mismatch count and a pass flag are
// reported, and done pulses for one cycle once the results are final.
//
// Parameters
//   EXPECTED  expected Y per vector, bit index = {A,B,C} (default: majority)
//   SETTLE    hold cycles before each sample cycle, 1..15
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   start     run request, honoured only in IDLE
//   A, B, C   stimulus to the block under test (A = vector MSB)
//   Y         response from the block under test
//   busy      high while vectors are being applied
//   done      one-cycle pulse when results are final
//   pass      1 when the last run had zero mismatches
//   err_cnt   mismatch count of the last run (0..8)
//   fail_vec  bit i set when vector i mismatched
//
// State table
//   IDLE   | stimulus parked at 000, waiting for start, results held
//   SETTLE | vector idx applied, counting down the settle time
//   SAMPLE | vector idx applied, Y compared at the edge ending this cycle
//   DONE   | stimulus parked, done high, results final for one cycle
// ---------------------------------------------------------------------------
module truth_table_checker #(
  parameter logic [7:0] EXPECTED = 8'b1110_1000,
  parameter int         SETTLE   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       Y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [7:0] fail_vec
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // The settle counter runs SETTLE-1 down to 0. That gives SETTLE cycles in
  // SETTLE, plus one SAMPLE cycle, for SETTLE+1 cycles per vector.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [2:0] vec;

  logic       mismatch;
  logic [3:0] err_next;

  // The stimulus lives in its own register. That keeps A/B/C glitch-free, and
  // they change only on clock edges.
  assign A = vec[2];
  assign B = vec[1];
  assign C = vec[0];

  assign mismatch = (Y != EXPECTED[idx]);
  assign err_next = err_cnt + {3'b000, mismatch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= 3'd0;
      cnt      <= 4'd0;
      vec      <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= 4'd0;
      fail_vec <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx      <= 3'd0;
            cnt      <= CNT_LOAD;
            vec      <= 3'd0;
            busy     <= 1'b1;
            err_cnt  <= 4'd0;
            fail_vec <= 8'd0;
            pass     <= 1'b0;
            state    <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= ST_SAMPLE;
          end
        end

        ST_SAMPLE: begin
          err_cnt <= err_next;
          if (mismatch) begin
            fail_vec[idx] <= 1'b1;
          end
          if (idx == 3'd7) begin
            // pass must include this last sample, so it is taken from the
            // count as it will be after this edge, not as it was before.
            vec   <= 3'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 4'd0);
            state <= ST_DONE;
          end else begin
            idx   <= idx + 3'd1;
            vec   <= idx + 3'd1;
            cnt   <= CNT_LOAD;
            state <= ST_SETTLE;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          vec   <= 3'd0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;

  logic a1, b1, c1, y1, busy1, done1, pass1;
  logic [3:0] err1;
  logic [7:0] fail1;
  logic a3, b3, c3, y3, busy3, done3, pass3;
  logic [3:0] err3;
  logic [7:0] fail3;

  // 0 = majority, 1 = stuck-at-0, 2 = inverted majority
  int ymode = 0;
  int sel = 1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign y1 = (ymode == 0) ? ((a1 & b1) | (a1 & c1) | (b1 & c1)) :
              (ymode == 1) ? 1'b0 : ~((a1 & b1) | (a1 & c1) | (b1 & c1));
  assign y3 = (ymode == 0) ? ((a3 & b3) | (a3 & c3) | (b3 & c3)) :
              (ymode == 1) ? 1'b0 : ~((a3 & b3) | (a3 & c3) | (b3 & c3));

  truth_table_checker #(.EXPECTED(8'hE8), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .C(c1), .Y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fail1)
  );

  truth_table_checker #(.EXPECTED(8'hE8), .SETTLE(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .A(a3), .B(b3), .C(c3), .Y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .fail_vec(fail3)
  );

  logic [2:0] abc_s;
  logic       busy_s, done_s, pass_s;
  logic [3:0] err_s;
  logic [7:0] fail_s;
  assign abc_s  = (sel == 3) ? {a3, b3, c3} : {a1, b1, c1};
  assign busy_s = (sel == 3) ? busy3 : busy1;
  assign done_s = (sel == 3) ? done3 : done1;
  assign pass_s = (sel == 3) ? pass3 : pass1;
  assign err_s  = (sel == 3) ? err3 : err1;
  assign fail_s = (sel == 3) ? fail3 : fail1;

  // Observations of one run, recorded #1 after each edge (index 0 = e0).
  logic [2:0] obs_abc [0:63];
  logic       obs_busy[0:63];
  int done_at, done_cnt;
  logic [3:0] res_err, clr_err;
  logic [7:0] res_fail, clr_fail;
  logic       res_pass, clr_pass;

  // Stimulus and recording only. Checks are done by the scenario tasks.
  task automatic run(input int sel_i, input int settle, input int pulse_at);
    int len;
    len = 8 * (settle + 1);
    sel = sel_i;
    done_at = -1;
    done_cnt = 0;
    res_err = 4'hX;
    res_fail = 8'hXX;
    res_pass = 1'bX;
    @(negedge clk);
    if (sel_i == 3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start3 = 1'b0;
    clr_err = err_s;
    clr_fail = fail_s;
    clr_pass = pass_s;
    for (int k = 0; k <= len + 4; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
      end
      if (k == pulse_at) begin
        if (sel_i == 3) start3 = 1'b1; else start1 = 1'b1;
      end
      obs_abc[k] = abc_s;
      obs_busy[k] = busy_s;
      if (done_s) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          res_err = err_s;
          res_fail = fail_s;
          res_pass = pass_s;
        end
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({a1, b1, c1, busy1, done1, pass1, err1, fail1} !== 18'd0) begin
      errors++;
      $display("FAIL reset_u1 got %h want 0", {a1, b1, c1, busy1, done1, pass1, err1, fail1});
    end
    checks++;
    if ({a3, b3, c3, busy3, done3, pass3, err3, fail3} !== 18'd0) begin
      errors++;
      $display("FAIL reset_u3 got %h want 0", {a3, b3, c3, busy3, done3, pass3, err3, fail3});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_correct;
    ymode = 0;
    run(1, 1, -1);
    checks++;
    if (clr_err !== 4'd0 || clr_fail !== 8'd0 || clr_pass !== 1'b0 ||
        obs_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL correct_e0 got err=%0d fail=%h pass=%b busy=%b want 0 00 0 1",
               clr_err, clr_fail, clr_pass, obs_busy[0]);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs_abc[k] !== 3'(k / 2) || obs_busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL correct_seq k=%0d got abc=%0d busy=%b want abc=%0d busy=1",
                 k, obs_abc[k], obs_busy[k], k / 2);
      end
    end
    checks++;
    if (obs_abc[16] !== 3'd0 || obs_busy[16] !== 1'b0) begin
      errors++;
      $display("FAIL correct_park got abc=%0d busy=%b want 0 0", obs_abc[16], obs_busy[16]);
    end
    checks++;
    if (done_at !== 16 || done_cnt !== 1) begin
      errors++;
      $display("FAIL correct_done got at=%0d cnt=%0d want 16 1", done_at, done_cnt);
    end
    checks++;
    if (res_pass !== 1'b1 || res_err !== 4'd0 || res_fail !== 8'h00) begin
      errors++;
      $display("FAIL correct_res got pass=%b err=%0d fail=%h want 1 0 00",
               res_pass, res_err, res_fail);
    end
  endtask

  task automatic test_stuck0;
    ymode = 1;
    run(1, 1, -1);
    checks++;
    if (done_at !== 16 || done_cnt !== 1) begin
      errors++;
      $display("FAIL stuck_done got at=%0d cnt=%0d want 16 1", done_at, done_cnt);
    end
    checks++;
    if (res_pass !== 1'b0 || res_err !== 4'd4 || res_fail !== 8'hE8) begin
      errors++;
      $display("FAIL stuck_res got pass=%b err=%0d fail=%h want 0 4 e8",
               res_pass, res_err, res_fail);
    end
    checks++;
    if (pass_s !== 1'b0 || err_s !== 4'd4 || fail_s !== 8'hE8 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL stuck_hold got pass=%b err=%0d fail=%h busy=%b want 0 4 e8 0",
               pass_s, err_s, fail_s, busy_s);
    end
  endtask

  task automatic test_inverted;
    ymode = 2;
    run(3, 3, -1);
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (obs_abc[k] !== 3'(k / 4) || obs_busy[k] !== 1'b1) begin
        errors++;
        $display("FAIL inv_seq k=%0d got abc=%0d busy=%b want abc=%0d busy=1",
                 k, obs_abc[k], obs_busy[k], k / 4);
      end
    end
    checks++;
    if (done_at !== 32 || done_cnt !== 1) begin
      errors++;
      $display("FAIL inv_done got at=%0d cnt=%0d want 32 1", done_at, done_cnt);
    end
    checks++;
    if (res_pass !== 1'b0 || res_err !== 4'd8 || res_fail !== 8'hFF) begin
      errors++;
      $display("FAIL inv_res got pass=%b err=%0d fail=%h want 0 8 ff",
               res_pass, res_err, res_fail);
    end
  endtask

  task automatic test_start_handling;
    ymode = 1;
    // start pulsed while vector 2 is applied (edges e0+4..e0+5)
    run(1, 1, 5);
    checks++;
    if (done_at !== 16 || done_cnt !== 1) begin
      errors++;
      $display("FAIL midstart_done got at=%0d cnt=%0d want 16 1", done_at, done_cnt);
    end
    checks++;
    if (res_err !== 4'd4 || res_fail !== 8'hE8 || res_pass !== 1'b0) begin
      errors++;
      $display("FAIL midstart_res got err=%0d fail=%h pass=%b want 4 e8 0",
               res_err, res_fail, res_pass);
    end
    // The previous run left err=4 and fail=e8. A new start must clear them.
    ymode = 0;
    run(1, 1, -1);
    checks++;
    if (clr_err !== 4'd0 || clr_fail !== 8'd0 || clr_pass !== 1'b0) begin
      errors++;
      $display("FAIL restart_clear got err=%0d fail=%h pass=%b want 0 00 0",
               clr_err, clr_fail, clr_pass);
    end
    checks++;
    if (done_at !== 16 || done_cnt !== 1 || res_pass !== 1'b1 || res_err !== 4'd0) begin
      errors++;
      $display("FAIL restart_res got at=%0d cnt=%0d pass=%b err=%0d want 16 1 1 0",
               done_at, done_cnt, res_pass, res_err);
    end
  endtask

  task automatic test_reset_mid_run;
    int dcnt;
    int bcnt;
    ymode = 2;
    sel = 1;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({a1, b1, c1} !== 3'd3 || err1 !== 4'd3 || fail1 !== 8'h07) begin
      errors++;
      $display("FAIL midrun_pre got abc=%0d err=%0d fail=%h want 3 3 07",
               {a1, b1, c1}, err1, fail1);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({a1, b1, c1, busy1, done1, pass1, err1, fail1} !== 18'd0) begin
      errors++;
      $display("FAIL midrun_rst got %h want 0", {a1, b1, c1, busy1, done1, pass1, err1, fail1});
    end
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    bcnt = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk);
      #1;
      if (done1) dcnt++;
      if (busy1) bcnt++;
    end
    checks++;
    if (dcnt !== 0 || bcnt !== 0) begin
      errors++;
      $display("FAIL midrun_nodone got done=%0d busy=%0d want 0 0", dcnt, bcnt);
    end
    ymode = 0;
    run(1, 1, -1);
    checks++;
    if (done_at !== 16 || done_cnt !== 1 || res_pass !== 1'b1 ||
        res_err !== 4'd0 || res_fail !== 8'h00) begin
      errors++;
      $display("FAIL midrun_rerun got at=%0d cnt=%0d pass=%b err=%0d fail=%h want 16 1 1 0 00",
               done_at, done_cnt, res_pass, res_err, res_fail);
    end
  endtask

  initial begin
    test_reset;
    test_correct;
    test_stuck0;
    test_inverted;
    test_start_handling;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
